// File: rtl/trv_dmem_ctrl.sv
// =============================================================================
// Module      : trv_dmem_ctrl
// Description : TRV32I data-memory controller with valid/ready requests, read
//               wait states, sub-word load/store and error responses.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module trv_dmem_ctrl #(
    parameter int B_WIDTH  = 32,
    parameter int MEM_SIZE = 32,
    parameter int RD_LAT   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [B_WIDTH-1:0] req_addr,
    input  logic [B_WIDTH-1:0] req_wdata,
    input  logic [1:0]         req_size,
    input  logic               req_unsigned,
    output logic               rsp_valid,
    output logic [B_WIDTH-1:0] rsp_rdata,
    output logic               rsp_err,
    output logic               busy
);
    localparam int NB  = B_WIDTH / 8;
    localparam int OFF = $clog2(NB);
    localparam int IW  = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic [3:0]         r_cnt;
    logic [1:0]         r_size;
    logic               r_uns;
    logic [OFF-1:0]     r_lane;
    logic [IW-1:0]      r_idx;
    logic [B_WIDTH-1:0] mem [MEM_SIZE];

    logic [OFF-1:0]     w_lane;
    logic [B_WIDTH-1:0] w_idx_full;
    logic [IW-1:0]      w_idx;
    logic               w_misalign;
    logic               w_err;
    logic               w_store_we;
    logic [NB-1:0]      w_be;
    logic [B_WIDTH-1:0] w_wdata_sh;

    function automatic logic [B_WIDTH-1:0] size_mask(input logic [1:0] size);
        int nbits;
        nbits = 8 << size;
        if (nbits >= B_WIDTH) return '1;
        return {B_WIDTH{1'b1}} >> (B_WIDTH - nbits);
    endfunction

    // Right-align the addressed lane bytes, then zero- or sign-extend.
    function automatic logic [B_WIDTH-1:0] extract(input logic [B_WIDTH-1:0] word,
                                                   input logic [OFF-1:0]     lane,
                                                   input logic [1:0]         size,
                                                   input logic               uns);
        logic [B_WIDTH-1:0] sh;
        logic [B_WIDTH-1:0] m;
        int                 nbits;
        sh    = word >> {lane, 3'b000};
        m     = size_mask(size);
        nbits = 8 << size;
        if (!uns && (nbits < B_WIDTH) && sh[nbits-1]) return (sh & m) | ~m;
        return sh & m;
    endfunction

    assign w_lane     = req_addr[OFF-1:0];
    assign w_idx_full = req_addr >> OFF;
    assign w_idx      = w_idx_full[IW-1:0];
    assign req_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);

    always_comb begin
        w_misalign = 1'b0;
        case (req_size)
            2'b01:   w_misalign = req_addr[0];
            2'b10:   w_misalign = |req_addr[1:0];
            2'b11:   w_misalign = (B_WIDTH == 32) || (|req_addr[2:0]);
            default: w_misalign = 1'b0;
        endcase
    end

    assign w_err      = w_misalign || (w_idx_full >= B_WIDTH'(MEM_SIZE));
    assign w_store_we = req_valid && req_ready && req_write && !w_err && !rst;
    assign w_wdata_sh = (req_wdata & size_mask(req_size)) << {w_lane, 3'b000};

    always_comb begin
        for (int b = 0; b < NB; b++) begin
            w_be[b] = (b >= int'(w_lane)) && (b < (int'(w_lane) + (1 << req_size)));
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_store_we) begin
            for (int b = 0; b < NB; b++) begin
                if (w_be[b]) mem[w_idx][b*8 +: 8] <= w_wdata_sh[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_size <= req_size;
                        r_uns  <= req_unsigned;
                        r_lane <= w_lane;
                        r_idx  <= w_idx;
                        if (w_err || req_write) begin
                            r_state   <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= w_err;
                            rsp_rdata <= '0;
                        end else if (RD_LAT == 0) begin
                            r_state   <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= extract(mem[w_idx], w_lane, req_size, req_unsigned);
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= 4'(RD_LAT - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state   <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= extract(mem[r_idx], r_lane, r_size, r_uns);
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_trv_dmem_ctrl.sv
// =============================================================================
// Module      : tb_trv_dmem_ctrl
// Description : Directed self-checking bench for trv_dmem_ctrl (32/64-bit).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_trv_dmem_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: 32-bit, RD_LAT = 1
    logic        rst_a, a_valid, a_ready, a_write, a_uns, a_rsp_valid, a_rsp_err, a_busy;
    logic [31:0] a_addr, a_wdata, a_rsp_rdata;
    logic [1:0]  a_size;
    // Instance B: 32-bit, RD_LAT = 3
    logic        rst_b, b_valid, b_ready, b_write, b_uns, b_rsp_valid, b_rsp_err, b_busy;
    logic [31:0] b_addr, b_wdata, b_rsp_rdata;
    logic [1:0]  b_size;
    // Instance C: 64-bit, RD_LAT = 0
    logic        rst_c, c_valid, c_ready, c_write, c_uns, c_rsp_valid, c_rsp_err, c_busy;
    logic [63:0] c_addr, c_wdata, c_rsp_rdata;
    logic [1:0]  c_size;

    trv_dmem_ctrl #(.B_WIDTH(32), .MEM_SIZE(32), .RD_LAT(1)) u_a (
        .clk(clk), .rst(rst_a), .req_valid(a_valid), .req_ready(a_ready),
        .req_write(a_write), .req_addr(a_addr), .req_wdata(a_wdata), .req_size(a_size),
        .req_unsigned(a_uns), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
        .rsp_err(a_rsp_err), .busy(a_busy));

    trv_dmem_ctrl #(.B_WIDTH(32), .MEM_SIZE(32), .RD_LAT(3)) u_b (
        .clk(clk), .rst(rst_b), .req_valid(b_valid), .req_ready(b_ready),
        .req_write(b_write), .req_addr(b_addr), .req_wdata(b_wdata), .req_size(b_size),
        .req_unsigned(b_uns), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err), .busy(b_busy));

    trv_dmem_ctrl #(.B_WIDTH(64), .MEM_SIZE(32), .RD_LAT(0)) u_c (
        .clk(clk), .rst(rst_c), .req_valid(c_valid), .req_ready(c_ready),
        .req_write(c_write), .req_addr(c_addr), .req_wdata(c_wdata), .req_size(c_size),
        .req_unsigned(c_uns), .rsp_valid(c_rsp_valid), .rsp_rdata(c_rsp_rdata),
        .rsp_err(c_rsp_err), .busy(c_busy));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic txn_a(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] sz, input logic uns, input logic [31:0] exp_d,
                         input logic exp_e, input int exp_lat, input string tag);
        int lat;
        @(posedge clk); #1;
        chk({tag, "_ready"}, 64'(a_ready), 64'd1);
        a_valid = 1'b1; a_write = wr; a_addr = addr; a_wdata = wd; a_size = sz; a_uns = uns;
        @(posedge clk); #1;
        a_valid = 1'b0;
        lat = 1;
        while (!a_rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_err"}, 64'(a_rsp_err), 64'(exp_e));
        chk({tag, "_data"}, 64'(a_rsp_rdata), 64'(exp_d));
    endtask

    task automatic txn_c(input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                         input logic [1:0] sz, input logic uns, input logic [63:0] exp_d,
                         input logic exp_e, input int exp_lat, input string tag);
        int lat;
        @(posedge clk); #1;
        chk({tag, "_ready"}, 64'(c_ready), 64'd1);
        c_valid = 1'b1; c_write = wr; c_addr = addr; c_wdata = wd; c_size = sz; c_uns = uns;
        @(posedge clk); #1;
        c_valid = 1'b0;
        lat = 1;
        while (!c_rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_err"}, 64'(c_rsp_err), 64'(exp_e));
        chk({tag, "_data"}, c_rsp_rdata, exp_d);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        a_valid = 0; a_write = 0; a_addr = 0; a_wdata = 0; a_size = 0; a_uns = 0;
        b_valid = 0; b_write = 0; b_addr = 0; b_wdata = 0; b_size = 0; b_uns = 0;
        c_valid = 0; c_write = 0; c_addr = 0; c_wdata = 0; c_size = 0; c_uns = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        chk("rst_ready", 64'(a_ready), 64'd1);
        chk("rst_valid", 64'(a_rsp_valid), 64'd0);
        chk("rst_rdata", 64'(a_rsp_rdata), 64'd0);
        chk("rst_err", 64'(a_rsp_err), 64'd0);
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_c_ready", 64'(c_ready), 64'd1);

        // Word store/load round trip
        txn_a(1, 32'h8, 32'hDEADBEEF, 2'b10, 0, 32'h0, 0, 1, "st_w8");
        txn_a(0, 32'h8, 32'h0, 2'b10, 0, 32'hDEADBEEF, 0, 2, "ld_w8");

        // Byte store with junk above the byte, then sub-word loads
        txn_a(1, 32'h9, 32'hAAAAAA80, 2'b00, 0, 32'h0, 0, 1, "st_b9");
        txn_a(0, 32'h9, 32'h0, 2'b00, 0, 32'hFFFFFF80, 0, 2, "ld_sb9");
        txn_a(0, 32'h9, 32'h0, 2'b00, 1, 32'h00000080, 0, 2, "ld_ub9");
        txn_a(0, 32'h8, 32'h0, 2'b10, 0, 32'hDEAD80EF, 0, 2, "ld_w8b");
        txn_a(0, 32'hA, 32'h0, 2'b01, 0, 32'hFFFFDEAD, 0, 2, "ld_sha");
        txn_a(0, 32'hA, 32'h0, 2'b01, 1, 32'h0000DEAD, 0, 2, "ld_uha");

        // Error responses; rejected stores must leave RAM untouched
        txn_a(0, 32'h3, 32'h0, 2'b01, 0, 32'h0, 1, 1, "err_h3");
        txn_a(0, 32'h82, 32'h0, 2'b10, 0, 32'h0, 1, 1, "err_w82");
        txn_a(0, 32'h80, 32'h0, 2'b10, 0, 32'h0, 1, 1, "err_oor");
        txn_a(1, 32'h9, 32'h00005555, 2'b01, 0, 32'h0, 1, 1, "err_sth9");
        txn_a(1, 32'hA, 32'h11111111, 2'b10, 0, 32'h0, 1, 1, "err_stwa");
        txn_a(0, 32'h8, 32'h0, 2'b11, 0, 32'h0, 1, 1, "err_sz11");
        txn_a(0, 32'h8, 32'h0, 2'b10, 0, 32'hDEAD80EF, 0, 2, "ld_w8c");

        // Reset in WAIT aborts the load
        @(posedge clk); #1;
        a_valid = 1'b1; a_write = 1'b0; a_addr = 32'h8; a_size = 2'b10; a_uns = 1'b0;
        @(posedge clk); #1;
        a_valid = 1'b0;
        chk("wait_busy", 64'(a_busy), 64'd1);
        rst_a = 1'b1;
        @(posedge clk); #1;
        rst_a = 1'b0;
        chk("abort_ready", 64'(a_ready), 64'd1);
        chk("abort_valid0", 64'(a_rsp_valid), 64'd0);
        @(posedge clk); #1;
        chk("abort_valid1", 64'(a_rsp_valid), 64'd0);
        // Store presented under reset is dropped
        a_valid = 1'b1; a_write = 1'b1; a_addr = 32'h8; a_wdata = 32'h12345678; a_size = 2'b10;
        rst_a = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0; a_write = 1'b0; rst_a = 1'b0;
        chk("rststore_valid", 64'(a_rsp_valid), 64'd0);
        chk("rststore_ready", 64'(a_ready), 64'd1);
        txn_a(0, 32'h8, 32'h0, 2'b10, 0, 32'hDEAD80EF, 0, 2, "ld_w8d");

        // Back-to-back loads with req_valid held high, RD_LAT = 3
        @(posedge clk); #1;
        b_valid = 1'b1; b_write = 1'b1; b_addr = 32'h4; b_wdata = 32'hCAFEF00D; b_size = 2'b10;
        @(posedge clk); #1;
        b_write = 1'b0;
        chk("b2b_st_valid", 64'(b_rsp_valid), 64'd1);
        chk("b2b_st_err", 64'(b_rsp_err), 64'd0);
        @(posedge clk); #1;
        chk("b2b_idle_ready", 64'(b_ready), 64'd1);
        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < 4; k++) begin
                @(posedge clk); #1;
                chk($sformatf("b2b_ready_%0d_%0d", n, k), 64'(b_ready), 64'd0);
                chk($sformatf("b2b_busy_%0d_%0d", n, k), 64'(b_busy), 64'd1);
                chk($sformatf("b2b_valid_%0d_%0d", n, k), 64'(b_rsp_valid), 64'(k == 3));
            end
            chk($sformatf("b2b_data_%0d", n), 64'(b_rsp_rdata), 64'hCAFEF00D);
            @(posedge clk); #1;
            if (n == 2) b_valid = 1'b0;
            chk($sformatf("b2b_rdy_hi_%0d", n), 64'(b_ready), 64'd1);
            chk($sformatf("b2b_busy_lo_%0d", n), 64'(b_busy), 64'd0);
            chk($sformatf("b2b_valid_lo_%0d", n), 64'(b_rsp_valid), 64'd0);
        end

        // 64-bit instance
        txn_c(1, 64'h10, 64'h0123456789ABCDEF, 2'b11, 0, 64'h0, 0, 1, "c_st_d10");
        txn_c(0, 64'h16, 64'h0, 2'b01, 0, 64'h0000000000000123, 0, 1, "c_ld_sh16");
        txn_c(0, 64'h13, 64'h0, 2'b00, 0, 64'hFFFFFFFFFFFFFF89, 0, 1, "c_ld_sb13");
        txn_c(0, 64'h10, 64'h0, 2'b10, 1, 64'h0000000089ABCDEF, 0, 1, "c_ld_uw10");
        txn_c(0, 64'h10, 64'h0, 2'b10, 0, 64'hFFFFFFFF89ABCDEF, 0, 1, "c_ld_sw10");
        txn_c(0, 64'h10, 64'h0, 2'b11, 0, 64'h0123456789ABCDEF, 0, 1, "c_ld_d10");
        txn_c(0, 64'h14, 64'h0, 2'b11, 0, 64'h0, 1, 1, "c_err_d14");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/trv_dmem_ctrl.md
Name: trv_dmem_ctrl

Overview:
Parametrised data-memory controller for the TRV32I core family; the successor to the single-cycle memory interface. It adds a valid/ready request handshake, configurable read wait states, sub-word load/store with sign/zero extension, and an error response for misaligned or out-of-range accesses. It sits between the core's load/store unit and a word-organised local data RAM held inside the block.

Parameters:
B_WIDTH, 32, data/address width in bits; legal values are 32 and 64.
MEM_SIZE, 32, RAM depth in B_WIDTH-bit words.
RD_LAT, 1, extra wait cycles on reads (0..15).

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request.
req_write  in  1  1 = store, 0 = load.
req_addr  in  B_WIDTH  byte address.
req_wdata  in  B_WIDTH  store data, right-aligned.
req_size  in  2  access size: 00 byte, 01 half, 10 word, 11 dword (dword legal only when B_WIDTH = 64).
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
rsp_valid  out  1  one-cycle response pulse.
rsp_rdata  out  B_WIDTH  load result; 0 for stores and errors.
rsp_err  out  1  qualifies rsp_valid; high means the access was rejected.
busy  out  1  high when the block is not in IDLE.

Behaviour:
- OFF = log2(B_WIDTH/8). Byte lane = req_addr[OFF-1:0]. Word index = req_addr >> OFF.
- FSM states: IDLE, WAIT, RESP. req_ready = (state == IDLE). A request is accepted on a clock edge where req_valid && req_ready.
- The block latches write, size, unsigned, lane, index and data at accept.
- Error check is evaluated at accept. An access is an error if any of the following holds:
  - half access with addr[0] = 1;
  - word access with addr[1:0] != 0;
  - dword access with addr[2:0] != 0;
  - size 11 when B_WIDTH = 32;
  - word index >= MEM_SIZE.
- On error: no RAM access; next state is RESP with rsp_err = 1 and rsp_rdata = 0.
- Store: the RAM is updated at the accept edge. Only the addressed bytes are written: byte enables cover 1, 2, 4 or 8 bytes starting at the byte lane. Data is req_wdata[size-1:0] shifted to the lane. Next state is RESP with rsp_err = 0 and rsp_rdata = 0.
- Load:
  - RD_LAT = 0: next state is RESP.
  - RD_LAT > 0: next state is WAIT with the counter loaded to RD_LAT-1. The counter decrements in WAIT; when it is 0, next state is RESP.
  - In RESP, rsp_rdata = extracted lane bytes, sign- or zero-extended to B_WIDTH. A full-width access is never extended.
- Latency from accept edge to the rsp_valid cycle: 1 cycle for stores and errors; 1+RD_LAT cycles for loads.
- RESP always returns to IDLE on the next edge. There is no response backpressure.
- Minimum request spacing is therefore 2 cycles.
- The RAM read occurs at the RESP transition. Data therefore reflects all earlier stores, including a store accepted immediately before.
- rsp_valid is high only in RESP. rsp_rdata and rsp_err hold their value outside RESP but are meaningful only with rsp_valid.
- Reset:
  - Applies to state, counter and outputs: state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0.
  - rst has priority over accept: a store presented in a cycle with rst high is not written.
  - Reset during WAIT or RESP aborts the access with no response pulse.
  - RAM contents are not cleared by reset.
- req_valid while req_ready = 0 is ignored. The requester must hold the request stable until it is accepted.

Test Plan:
1. Reset, then word store 0xDEADBEEF to addr 0x8, then load word addr 0x8 with RD_LAT = 1 -> store rsp_valid 1 cycle after accept with err = 0; load rsp_valid 2 cycles after accept with rdata = 0xDEADBEEF.
2. Byte store 0x80 to addr 0x9, then signed byte load at 0x9 -> 0xFFFFFF80. Unsigned byte load at 0x9 -> 0x00000080. Word load at 0x8 -> 0xDEAD80EF.
3. Half load at addr 0x3, and word load at addr 0x82 with MEM_SIZE = 32 -> each gives rsp_valid with rsp_err = 1 and rdata = 0; RAM is unchanged, checked by a later word load at 0x8 returning 0xDEAD80EF.
4. Hold req_valid high continuously for back-to-back loads with RD_LAT = 3 -> req_ready low for 4 cycles after each accept, exactly one rsp_valid pulse per request, busy mirrors !req_ready.
5. Assert rst in the WAIT cycle of a load -> no rsp_valid; req_ready = 1 in the following cycle. Then a store with rst held high -> the subsequent load returns the old data.
6. B_WIDTH = 64: dword store 0x0123456789ABCDEF at addr 0x10, then signed half load at 0x16 -> 0x0000000000000123. Size 11 with B_WIDTH = 32 -> rsp_err = 1.
